regwin_spill_fill: RTL and testbench
====================================

// Module: regwin_spill_fill
// PURPOSE
//  Initiator-side sequencer for the single-port 32x32 register file.
//  SPILL: reads NREGS consecutive registers and writes each to memory.
//  FILL: reads NREGS words from memory and writes each into consecutive registers.
//  Sits between the trap/window control logic (start/done) and the memory port.
//  Owns the register-file port while busy.
// PARAMETERS
//  NREGS        8   registers moved per operation (1..32)
//  ADDR_STRIDE  4   byte increment of mem_addr per register
// PORTS
//  clk        in   1   system clock, all state updates on posedge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   begin operation; sampled only in IDLE
//  op         in   1   0 = SPILL, 1 = FILL; captured with start
//  reg_base   in   5   first register index; captured with start
//  mem_base   in   32  first memory byte address; captured with start
//  busy       out  1   high whenever state != IDLE
//  done       out  1   one-cycle pulse when operation completes
//  rf_write   out  1   register-file write strobe (0 = read)
//  rf_addr    out  5   register-file address
//  rf_wdata   out  32  register-file write data
//  rf_rdata   in   32  register-file read data, registered: valid the cycle after the address is presented
//  mem_req    out  1   memory request; held until mem_gnt
//  mem_we     out  1   1 = write (SPILL), 0 = read (FILL)
//  mem_addr   out  32  memory byte address
//  mem_wdata  out  32  memory write data
//  mem_gnt    in   1   request accepted this cycle
//  mem_rvalid in   1   read data valid; earliest is the cycle after mem_gnt
//  mem_rdata  in   32  memory read data
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, idx=0.
//   - busy, done, rf_write, mem_req, mem_we = 0.
//   - rf_addr, rf_wdata, mem_addr, mem_wdata = 0.
//  Addressing (idx = 0..NREGS-1):
//   - rf_addr = (reg_base + idx) mod 32; wraps 31 -> 0.
//   - mem_addr = mem_base + idx*ADDR_STRIDE mod 2^32.
//  State machine:
//   - IDLE: start=1 -> capture op, reg_base, mem_base; idx=0.
//     Go to SP_RD if op=0, FL_REQ if op=1. Otherwise stay in IDLE.
//   - SP_RD: rf_write=0, rf_addr driven for one cycle -> SP_CAP.
//   - SP_CAP: latch rf_rdata into mem_wdata -> SP_PUSH.
//   - SP_PUSH: mem_req=1, mem_we=1, mem_addr and mem_wdata held stable.
//     On mem_gnt: if idx==NREGS-1 -> DONE, else idx++ -> SP_RD.
//   - FL_REQ: mem_req=1, mem_we=0. On mem_gnt -> FL_WAIT.
//   - FL_WAIT: on mem_rvalid, latch mem_rdata into rf_wdata -> FL_WR.
//   - FL_WR: rf_write=1 for exactly one cycle.
//     If idx==NREGS-1 -> DONE, else idx++ -> FL_REQ.
//   - DONE: done=1 for one cycle -> IDLE.
//  rf_write is 1 only in FL_WR. mem_req is 1 only in SP_PUSH and FL_REQ.
//  start is ignored while busy. mem_rvalid is ignored outside FL_WAIT.
//  Minimum latency, start to done:
//   - SPILL: 3*NREGS+1 cycles.
//   - FILL: 3*NREGS+1 cycles (gnt same cycle as req, rvalid the next cycle).
//  Stalls: mem_gnt=0 or a late mem_rvalid holds the current state and all outputs.
//  Reset mid-operation: abort immediately to IDLE with no done pulse.
//   Partially written registers or memory are left as-is.
// TESTING
//  - Reset: assert rst_n=0 mid-SPILL (idx=3) -> busy=0, done=0, mem_req=0 asynchronously; next start works.
//  - SPILL: reg_base=8, mem_base=0x100, gnt always 1, regs hold 0xA0+i ->
//    writes 0xA0..0xA7 to 0x100..0x11C; done at cycle 25.
//  - FILL: reg_base=16, mem_base=0x200, rdata=0x5000+idx, rvalid 1 cycle after gnt ->
//    r16..r23 = 0x5000..0x5007; done at cycle 25.
//  - Wrap: SPILL with reg_base=28 -> rf_addr sequence 28,29,30,31,0,1,2,3.
//  - Backpressure: hold mem_gnt=0 for 5 cycles in SP_PUSH -> mem_addr and mem_wdata stable; idx unchanged.
//  - Start while busy: pulse start with op=1 during a SPILL -> ignored; exactly one done, for the SPILL.

Source files
------------

// File: rtl/regwin_spill_fill.sv
// Register-window spill/fill sequencer: moves NREGS registers between the
// single-port register file and memory, owning the RF port while busy.
module regwin_spill_fill #(
  parameter int NREGS       = 8,
  parameter int ADDR_STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [4:0]  reg_base,
  input  logic [31:0] mem_base,
  output logic        busy,
  output logic        done,
  output logic        rf_write,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_SP_RD, S_SP_CAP, S_SP_PUSH, S_FL_REQ, S_FL_WAIT, S_FL_WR, S_DONE
  } state_t;

  localparam logic [4:0] LAST = 5'(NREGS - 1);

  state_t      state, state_nx;
  logic [4:0]  idx, idx_nx;
  logic [4:0]  reg_base_q;
  logic [31:0] mem_base_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rf_wdata_q;
  logic        capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture  = 1'b1;
          idx_nx   = '0;
          state_nx = op ? S_FL_REQ : S_SP_RD;
        end
      end
      S_SP_RD:  state_nx = S_SP_CAP;
      S_SP_CAP: state_nx = S_SP_PUSH;
      S_SP_PUSH: begin
        if (mem_gnt) begin
          if (idx == LAST) begin
            state_nx = S_DONE;
          end else begin
            idx_nx   = idx + 5'd1;
            state_nx = S_SP_RD;
          end
        end
      end
      S_FL_REQ:  if (mem_gnt) state_nx = S_FL_WAIT;
      S_FL_WAIT: if (mem_rvalid) state_nx = S_FL_WR;
      S_FL_WR: begin
        if (idx == LAST) begin
          state_nx = S_DONE;
        end else begin
          idx_nx   = idx + 5'd1;
          state_nx = S_FL_REQ;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_base_q  <= '0;
      mem_base_q  <= '0;
      mem_wdata_q <= '0;
      rf_wdata_q  <= '0;
    end else begin
      if (capture) begin
        reg_base_q <= reg_base;
        mem_base_q <= mem_base;
      end
      if (state == S_SP_CAP) mem_wdata_q <= rf_rdata;
      if (state == S_FL_WAIT && mem_rvalid) rf_wdata_q <= mem_rdata;
    end
  end

  // Addresses derive from captured bases plus idx, so they hold through stalls.
  assign rf_addr   = reg_base_q + idx;
  assign mem_addr  = mem_base_q + 32'(idx) * 32'(ADDR_STRIDE);
  assign mem_wdata = mem_wdata_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign rf_write  = (state == S_FL_WR);
  assign mem_req   = (state == S_SP_PUSH) || (state == S_FL_REQ);
  assign mem_we    = (state == S_SP_PUSH);

endmodule

// File: tb/tb_regwin_spill_fill.sv
// Self-checking bench for regwin_spill_fill: behavioural RF and memory
// models, directed spec scenarios plus randomized spill/fill operations.
module tb_regwin_spill_fill;
  localparam int NREGS = 8;
  localparam int STRIDE = 4;

  logic        clk = 0, rst_n = 0;
  logic        start = 0, op = 0;
  logic [4:0]  reg_base = 0;
  logic [31:0] mem_base = 0;
  logic        busy, done, rf_write, mem_req, mem_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata, rf_rdata, mem_addr, mem_wdata;
  logic        mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;

  regwin_spill_fill #(.NREGS(NREGS), .ADDR_STRIDE(STRIDE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .reg_base(reg_base),
    .mem_base(mem_base), .busy(busy), .done(done), .rf_write(rf_write),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [31:0] regs [32];
  logic [31:0] mem [logic [31:0]];
  int gnt_mode = 0;   // 0 always grant, 1 random, 2 never
  int rv_max = 0;     // max extra rvalid delay
  bit noise = 0;      // spurious rvalid outside pending reads
  int done_cnt = 0, wr_cnt = 0, rfw_cnt = 0;
  bit pend = 0, deliv = 0;
  int dly = 0;
  logic [31:0] paddr = 0;

  initial rf_rdata = 0;
  always @(posedge clk) begin
    if (rf_write) regs[rf_addr] <= rf_wdata;
    rf_rdata <= regs[rf_addr];
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rf_write) rfw_cnt++;
    if (mem_rvalid) begin
      mem_rvalid = 0;
      if (deliv) begin pend = 0; deliv = 0; end
    end else if (pend) begin
      if (dly == 0) begin
        mem_rvalid = 1;
        mem_rdata  = mem.exists(paddr) ? mem[paddr] : (32'hDEAD0000 ^ paddr);
        deliv = 1;
      end else dly--;
    end else if (noise && $urandom_range(0, 3) == 0) begin
      mem_rvalid = 1;
      mem_rdata  = $urandom;
    end
    mem_gnt = rst_n && mem_req &&
              (gnt_mode == 0 || (gnt_mode == 1 && $urandom_range(0, 1) == 1));
    if (mem_gnt) begin
      wr_cnt++;
      if (mem_we) mem[mem_addr] = mem_wdata;
      else begin
        pend = 1; paddr = mem_addr; dly = $urandom_range(0, rv_max);
      end
    end
  end

  task automatic run_op(input logic o, input logic [4:0] rb, input logic [31:0] mb,
                        input int poke, output int cyc);
    op = o; reg_base = rb; mem_base = mb; start = 1;
    @(posedge clk); #1;
    start = 0; cyc = 1;
    while (!done && cyc < 3000) begin
      if (cyc == poke) begin start = 1; op = ~o; end else start = 0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    checks++;
    if (!done) begin
      failures++; $display("FAIL op_timeout: done not seen after %0d cycles", cyc);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_done: busy=%b required 0", busy);
    end
  endtask

  task automatic check_spill(input logic [4:0] rb, input logic [31:0] mb,
                             input logic [31:0] exp [NREGS], input string nm);
    for (int i = 0; i < NREGS; i++) begin
      logic [31:0] a;
      a = mb + 32'(i * STRIDE);
      checks++;
      if (!mem.exists(a) || mem[a] !== exp[i]) begin
        failures++;
        $display("FAIL %s mem[%h]: got %h required %h (reg %0d)", nm, a,
                 mem.exists(a) ? mem[a] : 32'hx, exp[i], (rb + i) % 32);
      end
    end
  endtask

  task automatic do_spill(input logic [4:0] rb, input logic [31:0] mb, input int poke,
                          input int exp_lat, input string nm);
    logic [31:0] exp [NREGS];
    int cyc, d0, w0, r0;
    for (int i = 0; i < NREGS; i++) exp[i] = regs[(int'(rb) + i) % 32];
    d0 = done_cnt; w0 = wr_cnt; r0 = rfw_cnt;
    run_op(1'b0, rb, mb, poke, cyc);
    check_spill(rb, mb, exp, nm);
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++; $display("FAIL %s done_count: got %0d required 1", nm, done_cnt - d0);
    end
    checks++;
    if (wr_cnt - w0 != NREGS || rfw_cnt != r0) begin
      failures++;
      $display("FAIL %s transfers: mem=%0d rf_write=%0d required %0d/0", nm, wr_cnt - w0,
               rfw_cnt - r0, NREGS);
    end
    checks++;
    if (exp_lat > 0 ? cyc != exp_lat : cyc < 3 * NREGS + 1) begin
      failures++; $display("FAIL %s latency: got %0d required %0d", nm, cyc, exp_lat);
    end
  endtask

  task automatic do_fill(input logic [4:0] rb, input logic [31:0] mb, input int exp_lat,
                         input string nm);
    logic [31:0] exp [32];
    int cyc, d0;
    for (int i = 0; i < 32; i++) exp[i] = regs[i];
    for (int i = 0; i < NREGS; i++) begin
      logic [31:0] a;
      a = mb + 32'(i * STRIDE);
      exp[(int'(rb) + i) % 32] = mem.exists(a) ? mem[a] : (32'hDEAD0000 ^ a);
    end
    d0 = done_cnt;
    run_op(1'b1, rb, mb, -1, cyc);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (regs[i] !== exp[i]) begin
        failures++; $display("FAIL %s r%0d: got %h required %h", nm, i, regs[i], exp[i]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++; $display("FAIL %s done_count: got %0d required 1", nm, done_cnt - d0);
    end
    checks++;
    if (exp_lat > 0 ? cyc != exp_lat : cyc < 3 * NREGS + 1) begin
      failures++; $display("FAIL %s latency: got %0d required %0d", nm, cyc, exp_lat);
    end
  endtask

  task automatic test_reset_state();
    checks++;
    if ({busy, done, rf_write, mem_req, mem_we} !== 5'b0 || rf_addr !== 5'd0 ||
        rf_wdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: b/d/rw/rq/we=%b%b%b%b%b rf_addr=%h mem_addr=%h required all 0",
               busy, done, rf_write, mem_req, mem_we, rf_addr, mem_addr);
    end
  endtask

  task automatic test_spill();
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    for (int i = 0; i < NREGS; i++) regs[8 + i] = 32'hA0 + 32'(i);
    gnt_mode = 0;
    do_spill(5'd8, 32'h100, -1, 25, "spill");
  endtask

  task automatic test_fill();
    gnt_mode = 0; rv_max = 0;
    for (int i = 0; i < NREGS; i++) mem[32'h200 + 32'(i * 4)] = 32'h5000 + 32'(i);
    do_fill(5'd16, 32'h200, 25, "fill");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 32; i++) regs[i] = 32'hC000 + 32'(i);
    do_spill(5'd28, 32'h400, -1, 25, "wrap");
  endtask

  task automatic test_backpressure();
    logic [31:0] a0, d0;
    int cyc;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    gnt_mode = 2;
    op = 0; reg_base = 5'd3; mem_base = 32'h800; start = 1;
    @(posedge clk); #1; start = 0; cyc = 1;
    while (!mem_req && cyc < 20) begin @(posedge clk); #1; cyc++; end
    a0 = mem_addr; d0 = mem_wdata;
    checks++;
    if (!mem_req || a0 !== 32'h800 || d0 !== regs[3]) begin
      failures++;
      $display("FAIL bp_first_push: req=%b addr=%h data=%h required 1/00000800/%h",
               mem_req, a0, d0, regs[3]);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (!mem_req || !mem_we || mem_addr !== a0 || mem_wdata !== d0) begin
        failures++;
        $display("FAIL bp_stable[%0d]: req=%b addr=%h data=%h required 1/%h/%h", k, mem_req,
                 mem_addr, mem_wdata, a0, d0);
      end
    end
    gnt_mode = 0;
    while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    for (int i = 0; i < NREGS; i++) begin
      checks++;
      if (mem[32'h800 + 32'(i * 4)] !== regs[3 + i]) begin
        failures++; $display("FAIL bp_data[%0d]: got %h required %h", i,
                             mem[32'h800 + 32'(i * 4)], regs[3 + i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    gnt_mode = 0;
    do_spill(5'd12, 32'h1000, 6, 25, "busy_start");
  endtask

  task automatic test_reset_mid();
    int cyc, d0, w0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    gnt_mode = 0;
    d0 = done_cnt; w0 = wr_cnt;
    op = 0; reg_base = 5'd0; mem_base = 32'h3000; start = 1;
    @(posedge clk); #1; start = 0; cyc = 1;
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    rst_n = 0; #1;
    checks++;
    if (busy !== 0 || done !== 0 || mem_req !== 0 || rf_write !== 0 || mem_addr !== 0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b req=%b addr=%h required 0", busy, done,
               mem_req, mem_addr);
    end
    #3 rst_n = 1;
    @(posedge clk); #1; @(posedge clk); #1;
    checks++;
    if (done_cnt != d0 || wr_cnt - w0 != 3) begin
      failures++;
      $display("FAIL reset_abort: dones=%0d writes=%0d required 0/3", done_cnt - d0,
               wr_cnt - w0);
    end
    rv_max = 0;
    for (int i = 0; i < NREGS; i++) mem[32'h3400 + 32'(i * 4)] = $urandom;
    do_fill(5'd5, 32'h3400, 25, "fill_after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      logic [4:0] rb;
      logic [31:0] mb;
      rb = 5'($urandom);
      mb = $urandom & 32'hFFFF_FFFC;
      if (n % 5 == 0) mb = 32'hFFFF_FFF0;
      gnt_mode = 1; rv_max = 3; noise = 1;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < NREGS; i++) mem[mb + 32'(i * 4)] = $urandom;
        do_fill(rb, mb, 0, "rand_fill");
      end else do_spill(rb, mb, -1, 0, "rand_spill");
    end
    noise = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 0;
    #12;
    test_reset_state();
    rst_n = 1;
    @(posedge clk); #1;
    test_spill();
    test_fill();
    test_wrap();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
